// File: rtl/spi_reg_arbiter_pkg.sv
// Shared constants and types for the SPI register file / access arbiter.
package spi_reg_arbiter_pkg;

    localparam int ADDR_W   = 6;
    localparam int DATA_W   = 8;
    localparam int NUM_REGS = 64;

    // Default start of the SPI-read-only status region (RO_BASE..6'h3F).
    localparam logic [ADDR_W-1:0] RO_BASE_DEFAULT = 6'h30;

    // Register map: control region.
    localparam logic [ADDR_W-1:0] REG_CTRL        = 6'h00;
    localparam logic [ADDR_W-1:0] REG_MOTOR0_CMD  = 6'h01;
    localparam logic [ADDR_W-1:0] REG_MOTOR0_DUTY = 6'h02;
    localparam logic [ADDR_W-1:0] REG_MOTOR1_CMD  = 6'h03;
    localparam logic [ADDR_W-1:0] REG_MOTOR1_DUTY = 6'h04;
    // Register map: status region, written only by on-chip requesters.
    localparam logic [ADDR_W-1:0] REG_STATUS      = 6'h30;
    localparam logic [ADDR_W-1:0] REG_ENC0_COUNT  = 6'h31;
    localparam logic [ADDR_W-1:0] REG_ENC1_COUNT  = 6'h32;

    // One captured SPI access waiting for its service cycle.
    typedef struct packed {
        logic              is_read;   // read, or write+read conflict
        logic              conflict;  // both enables arrived together
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } spi_req_t;

    function automatic logic is_ro_addr(input logic [ADDR_W-1:0] addr,
                                        input logic [ADDR_W-1:0] ro_base);
        return addr >= ro_base;
    endfunction

endpackage

// File: rtl/spi_reg_arbiter_rr_arbiter.sv
// Generic round-robin arbiter: one-hot combinational grant, pointer moves
// to (granted index + 1) after every grant.
module rr_arbiter #(
    parameter int N = 2
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic [N-1:0] req,
    input  logic         enable,
    output logic [N-1:0] gnt
);

    localparam int PTR_W = (N > 1) ? $clog2(N) : 1;

    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic             found;
    int               idx;

    // Search from the pointer for the first active request; grant it and move the pointer past it.
    always_comb begin
        // NOTE: every signal written here gets a default first so no latch is inferred.
        gnt   = '0;
        ptr_d = ptr_q;
        found = 1'b0;
        idx   = 0;
        if (enable) begin
            for (int k = 0; k < N; k++) begin
                idx = (int'(ptr_q) + k) % N;
                if (!found && req[idx]) begin
                    found    = 1'b1;
                    gnt[idx] = 1'b1;
                    ptr_d    = PTR_W'((idx + 1) % N);
                end
            end
        end
    end

    // Pointer register.
    always_ff @(posedge clock or negedge reset_n) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (!reset_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/spi_reg_arbiter.sv
// 64 x 8 control/status register file shared by the SPI slave and on-chip
// requesters. A captured SPI access always wins the following cycle;
// otherwise internal requesters are served round-robin, one access per cycle.
module spi_reg_arbiter
    import spi_reg_arbiter_pkg::*;
#(
    parameter int                NUM_REQ = 2,
    parameter logic [ADDR_W-1:0] RO_BASE = RO_BASE_DEFAULT
) (
    input  logic                        clock,
    input  logic                        reset_n,
    input  logic                        spi_write_en,
    input  logic                        spi_read_en,
    input  logic [ADDR_W-1:0]           spi_address,
    input  logic [DATA_W-1:0]           spi_wr_data,
    output logic [DATA_W-1:0]           spi_rd_data,
    output logic                        spi_wr_err,
    input  logic [NUM_REQ-1:0]          int_req,
    input  logic [NUM_REQ-1:0]          int_we,
    input  logic [NUM_REQ*ADDR_W-1:0]   int_addr,
    input  logic [NUM_REQ*DATA_W-1:0]   int_wdata,
    output logic [NUM_REQ-1:0]          int_gnt,
    output logic [DATA_W-1:0]           int_rdata,
    output logic [NUM_REQ-1:0]          int_rvalid,
    output logic [NUM_REGS*DATA_W-1:0]  reg_q
);

    logic                spi_pend_q, spi_pend_d;
    spi_req_t            spi_q, spi_d;
    logic [DATA_W-1:0]   regs_q [NUM_REGS];
    logic [DATA_W-1:0]   regs_d [NUM_REGS];
    logic [DATA_W-1:0]   spi_rd_data_q, spi_rd_data_d;
    logic [DATA_W-1:0]   int_rdata_q, int_rdata_d;
    logic [NUM_REQ-1:0]  int_rvalid_q, int_rvalid_d;

    logic                sel_we;
    logic [ADDR_W-1:0]   sel_addr;
    logic [DATA_W-1:0]   sel_wdata;

    // Internal requests are ignored during reset and in every SPI service cycle.
    rr_arbiter #(.N(NUM_REQ)) u_rr_arbiter (
        .clock   (clock),
        .reset_n (reset_n),
        .req     (int_req),
        .enable  (reset_n & ~spi_pend_q),
        .gnt     (int_gnt)
    );

    // Capture an SPI pulse; a simultaneous write+read degrades to a flagged read.
    always_comb begin
        spi_pend_d = spi_write_en | spi_read_en;
        spi_d      = spi_q;
        if (spi_write_en | spi_read_en) begin
            spi_d.is_read  = spi_read_en;
            spi_d.conflict = spi_write_en & spi_read_en;
            spi_d.addr     = spi_address;
            spi_d.data     = spi_wr_data;
        end
    end

    // Pick the fields of the granted internal requester.
    always_comb begin
        sel_we    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (int_gnt[i]) begin
                sel_we    = int_we[i];
                sel_addr  = int_addr[i*ADDR_W +: ADDR_W];
                sel_wdata = int_wdata[i*DATA_W +: DATA_W];
            end
        end
    end

    // Execute the single access of this cycle: pending SPI first, else the internal grant.
    always_comb begin
        regs_d        = regs_q;
        spi_rd_data_d = spi_rd_data_q;
        int_rdata_d   = int_rdata_q;
        int_rvalid_d  = '0;
        spi_wr_err    = 1'b0;
        if (spi_pend_q) begin
            if (spi_q.is_read) begin
                spi_rd_data_d = regs_q[spi_q.addr];
                spi_wr_err    = spi_q.conflict;
            end else if (is_ro_addr(spi_q.addr, RO_BASE)) begin
                spi_wr_err = 1'b1;
            end else begin
                regs_d[spi_q.addr] = spi_q.data;
            end
        end else if (|int_gnt) begin
            if (sel_we) begin
                regs_d[sel_addr] = sel_wdata;
            end else begin
                int_rdata_d  = regs_q[sel_addr];
                int_rvalid_d = int_gnt;
            end
        end
    end

    // Flat view of the register array for direct control wiring.
    always_comb begin
        reg_q = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            reg_q[i*DATA_W +: DATA_W] = regs_q[i];
        end
    end

    // State registers; any in-flight SPI request or read response is dropped on reset.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            spi_pend_q    <= 1'b0;
            spi_q         <= '0;
            spi_rd_data_q <= '0;
            int_rdata_q   <= '0;
            int_rvalid_q  <= '0;
            // NOTE: the array is built from flops (not RAM), so clearing it on reset is legal and required.
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            spi_pend_q    <= spi_pend_d;
            spi_q         <= spi_d;
            spi_rd_data_q <= spi_rd_data_d;
            int_rdata_q   <= int_rdata_d;
            int_rvalid_q  <= int_rvalid_d;
            regs_q        <= regs_d;
        end
    end

    assign spi_rd_data = spi_rd_data_q;
    assign int_rdata   = int_rdata_q;
    assign int_rvalid  = int_rvalid_q;

endmodule

// File: tb/tb_spi_reg_arbiter.sv
// Self-checking bench for spi_reg_arbiter: a cycle-level reference model
// predicts grants, errors and register contents; read responses go through
// a scoreboard queue and are compared when the DUT returns them.
module tb_spi_reg_arbiter;
    import spi_reg_arbiter_pkg::*;

    localparam int                NUM_REQ = 2;
    localparam logic [ADDR_W-1:0] RO_BASE = RO_BASE_DEFAULT;

    logic                        clock;
    logic                        reset_n;
    logic                        spi_write_en;
    logic                        spi_read_en;
    logic [ADDR_W-1:0]           spi_address;
    logic [DATA_W-1:0]           spi_wr_data;
    logic [DATA_W-1:0]           spi_rd_data;
    logic                        spi_wr_err;
    logic [NUM_REQ-1:0]          int_req;
    logic [NUM_REQ-1:0]          int_we;
    logic [NUM_REQ*ADDR_W-1:0]   int_addr;
    logic [NUM_REQ*DATA_W-1:0]   int_wdata;
    logic [NUM_REQ-1:0]          int_gnt;
    logic [DATA_W-1:0]           int_rdata;
    logic [NUM_REQ-1:0]          int_rvalid;
    logic [NUM_REGS*DATA_W-1:0]  reg_q;

    spi_reg_arbiter #(.NUM_REQ(NUM_REQ), .RO_BASE(RO_BASE)) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .spi_write_en (spi_write_en),
        .spi_read_en  (spi_read_en),
        .spi_address  (spi_address),
        .spi_wr_data  (spi_wr_data),
        .spi_rd_data  (spi_rd_data),
        .spi_wr_err   (spi_wr_err),
        .int_req      (int_req),
        .int_we       (int_we),
        .int_addr     (int_addr),
        .int_wdata    (int_wdata),
        .int_gnt      (int_gnt),
        .int_rdata    (int_rdata),
        .int_rvalid   (int_rvalid),
        .reg_q        (reg_q)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Scoreboard of expected read responses.
    typedef struct {
        int           due;
        bit           is_int;
        int           idx;
        logic [7:0]   data;
    } sb_item_t;

    sb_item_t sb[$];

    // Reference model state.
    logic [7:0]  mdl [NUM_REGS];
    logic        pend_m, rd_m, cf_m;
    logic [5:0]  addr_m;
    logic [7:0]  data_m;
    int          ptr_m;

    // Reference model and monitor, evaluated mid-cycle on the falling edge.
    always @(negedge clock) begin : model
        logic [NUM_REQ-1:0] exp_rv, exp_gnt;
        logic               exp_err;
        logic [511:0]       flat;
        sb_item_t           it;
        bit                 found;
        int                 idx;
        if (!reset_n) begin
            for (int i = 0; i < NUM_REGS; i++) mdl[i] = 8'h00;
            pend_m = 1'b0;
            ptr_m  = 0;
            sb.delete();
            check("rst_reg_q",      512'(reg_q),       512'(0));
            check("rst_int_gnt",    512'(int_gnt),     512'(0));
            check("rst_int_rvalid", 512'(int_rvalid),  512'(0));
            check("rst_spi_rd",     512'(spi_rd_data), 512'(0));
            check("rst_wr_err",     512'(spi_wr_err),  512'(0));
        end else begin
            for (int i = 0; i < NUM_REGS; i++) flat[i*8 +: 8] = mdl[i];
            check("reg_q", 512'(reg_q), flat);

            exp_rv = '0;
            while (sb.size() > 0 && sb[0].due == cyc) begin
                it = sb.pop_front();
                if (it.is_int) begin
                    exp_rv[it.idx] = 1'b1;
                    check("int_rdata", 512'(int_rdata), 512'(it.data));
                end else begin
                    check("spi_rd_data", 512'(spi_rd_data), 512'(it.data));
                end
            end
            check("int_rvalid", 512'(int_rvalid), 512'(exp_rv));

            exp_gnt = '0;
            exp_err = 1'b0;
            found   = 0;
            if (pend_m) begin
                if (rd_m) begin
                    sb.push_back('{due: cyc + 1, is_int: 1'b0, idx: 0, data: mdl[addr_m]});
                    exp_err = cf_m;
                end else if (addr_m >= RO_BASE) begin
                    exp_err = 1'b1;
                end else begin
                    mdl[addr_m] = data_m;
                end
            end else begin
                for (int k = 0; k < NUM_REQ; k++) begin
                    idx = (ptr_m + k) % NUM_REQ;
                    if (!found && int_req[idx]) begin
                        found        = 1;
                        exp_gnt[idx] = 1'b1;
                        ptr_m        = (idx + 1) % NUM_REQ;
                        if (int_we[idx])
                            mdl[int_addr[idx*6 +: 6]] = int_wdata[idx*8 +: 8];
                        else
                            sb.push_back('{due: cyc + 1, is_int: 1'b1, idx: idx,
                                           data: mdl[int_addr[idx*6 +: 6]]});
                    end
                end
            end
            check("int_gnt",    512'(int_gnt),    512'(exp_gnt));
            check("spi_wr_err", 512'(spi_wr_err), 512'(exp_err));

            pend_m = spi_write_en | spi_read_en;
            rd_m   = spi_read_en;
            cf_m   = spi_write_en & spi_read_en;
            addr_m = spi_address;
            data_m = spi_wr_data;
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic spi_pulse(input logic wr, input logic rd, input logic [5:0] a, input logic [7:0] d);
        spi_write_en = wr;
        spi_read_en  = rd;
        spi_address  = a;
        spi_wr_data  = d;
        tick();
        spi_write_en = 1'b0;
        spi_read_en  = 1'b0;
    endtask

    task automatic int_access(input int i, input logic we, input logic [5:0] a, input logic [7:0] d);
        bit got = 0;
        int_req[i]          = 1'b1;
        int_we[i]           = we;
        int_addr[i*6 +: 6]  = a;
        int_wdata[i*8 +: 8] = d;
        for (int n = 0; n < 20 && !got; n++) begin
            @(negedge clock);
            if (int_gnt[i]) got = 1;
            else tick();
        end
        if (!got) check("gnt_timeout", 512'(int_gnt[i]), 512'(1));
        tick();
        int_req[i] = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset_n      = 1'b0;
        spi_write_en = 1'b0;
        spi_read_en  = 1'b0;
        spi_address  = '0;
        spi_wr_data  = '0;
        int_req      = '0;
        int_we       = '0;
        int_addr     = '0;
        int_wdata    = '0;
        repeat (3) @(posedge clock);
        #1 reset_n = 1'b1;
        tick();

        // SPI write then read of 0x05.
        spi_pulse(1'b1, 1'b0, 6'h05, 8'hA5);
        spi_pulse(1'b0, 1'b1, 6'h05, 8'h00);
        @(negedge clock);
        check("t1_reg05_n2", 512'(reg_q[8*5 +: 8]), 512'(8'hA5));
        tick();
        @(negedge clock);
        check("t1_spi_rd05", 512'(spi_rd_data), 512'(8'hA5));
        tick();

        // Round-robin between two readers of 0x02 / 0x03.
        spi_pulse(1'b1, 1'b0, 6'h02, 8'h22);
        spi_pulse(1'b1, 1'b0, 6'h03, 8'h33);
        tick();
        int_we    = 2'b00;
        int_addr  = {6'h03, 6'h02};
        int_req   = 2'b11;
        for (int k = 0; k < 6; k++) begin
            @(negedge clock);
            check("alt_gnt", 512'(int_gnt), 512'((k % 2) ? 2'b10 : 2'b01));
            tick();
        end
        int_req = 2'b00;
        tick();

        // SPI write into the read-only region is dropped and flagged.
        spi_pulse(1'b1, 1'b0, 6'h31, 8'h7E);
        @(negedge clock);
        check("ro_err", 512'(spi_wr_err), 512'(1));
        tick();
        @(negedge clock);
        check("ro_unchanged", 512'(reg_q[8*'h31 +: 8]), 512'(0));
        check("ro_err_once",  512'(spi_wr_err),         512'(0));
        tick();
        int_access(0, 1'b1, 6'h31, 8'h7E);
        spi_pulse(1'b0, 1'b1, 6'h31, 8'h00);
        tick();
        @(negedge clock);
        check("ro_int_rd31", 512'(spi_rd_data), 512'(8'h7E));
        tick();

        // Internal requester stalls for the SPI service cycle.
        spi_pulse(1'b1, 1'b0, 6'h10, 8'h11);
        int_we[1]        = 1'b1;
        int_addr[6 +: 6] = 6'h11;
        int_wdata[8 +: 8] = 8'h22;
        int_req[1]       = 1'b1;
        @(negedge clock);
        check("svc_gnt_low", 512'(int_gnt), 512'(0));
        tick();
        @(negedge clock);
        check("int_after_spi", 512'(int_gnt), 512'(2'b10));
        tick();
        int_req[1] = 1'b0;
        tick();
        @(negedge clock);
        check("both_land_10", 512'(reg_q[8*'h10 +: 8]), 512'(8'h11));
        check("both_land_11", 512'(reg_q[8*'h11 +: 8]), 512'(8'h22));
        tick();

        // Write and read together: treated as a read and flagged.
        spi_pulse(1'b1, 1'b1, 6'h04, 8'h44);
        @(negedge clock);
        check("conflict_err", 512'(spi_wr_err), 512'(1));
        tick();
        @(negedge clock);
        check("conflict_reg04", 512'(reg_q[8*4 +: 8]), 512'(0));
        check("conflict_rd04",  512'(spi_rd_data),     512'(0));
        tick();

        // Reset right after an SPI pulse, with an internal read in flight.
        int_we[0]        = 1'b0;
        int_addr[0 +: 6] = 6'h05;
        int_req[0]       = 1'b1;
        spi_pulse(1'b1, 1'b0, 6'h06, 8'h55);
        reset_n = 1'b0;
        repeat (3) tick();
        int_req = '0;
        tick();
        reset_n = 1'b1;
        tick();
        tick();
        @(negedge clock);
        check("post_rst_reg_q",  512'(reg_q),       512'(0));
        check("post_rst_spi_rd", 512'(spi_rd_data), 512'(0));
        check("post_rst_int_rd", 512'(int_rdata),   512'(0));
        check("post_rst_rvalid", 512'(int_rvalid),  512'(0));
        tick();
        spi_pulse(1'b0, 1'b1, 6'h06, 8'h00);
        tick();
        @(negedge clock);
        check("post_rst_rd06", 512'(spi_rd_data), 512'(0));
        tick();

        repeat (3) tick();
        check("sb_empty", 512'(sb.size()), 512'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
